sect239k1_pt_mul_if: RTL and testbench

Word-serial command/response front end for the sect239k1 point-multiplication core. Accepts a 239-bit scalar as eight 32-bit words on a valid/ready input stream and assembles it. It then acts as the initiator of the core's start/done protocol: pulses `start`, waits for `done`, and captures x/y. Finally it streams the result out as sixteen 32-bit words on a valid/ready output stream. It sits between a bus-side DMA/FIFO and `sect239k1_pt_mul`, replacing the bench-style driver/monitor with synthesizable control.

---
 rtl/sect239k1_pt_mul_if.sv | 177 +++++++++++++++++
 tb/tb_sect239k1_pt_mul_if.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sect239k1_pt_mul_if.sv
// rtl/sect239k1_pt_mul_if.sv - word-serial command/response front end for the sect239k1 point-multiplication core
//
// Collects a 239-bit scalar as eight 32-bit words (LSW first), starts the core,
// waits for a rising edge on its done output, captures x/y and streams them back
// as sixteen 32-bit words (x words 0..7, then y words 0..7, LSW first).
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   clr                   synchronous abort; also forwarded to core_clr
//   s_valid/s_ready/s_data  scalar word input stream
//   m_valid/m_ready/m_data/m_last  result word output stream
//   busy                  high outside LOAD
//   err                   sticky watchdog timeout flag
//   core_clr/core_start/core_d  to the core
//   core_done/core_x/core_y     from the core
//
// Optional feature: define SECT239K1_PT_MUL_IF_TIMEOUT_EN to enable the WAIT
// watchdog (limit TimeoutCycles). Without it err is 0 and WAIT never times out.

module sect239k1_pt_mul_if #(
  parameter int unsigned TimeoutCycles = 1000000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [31:0]  s_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [31:0]  m_data,
  output logic         m_last,
  output logic         busy,
  output logic         err,
  output logic         core_clr,
  output logic         core_start,
  output logic [238:0] core_d,
  input  logic         core_done,
  input  logic [238:0] core_x,
  input  logic [238:0] core_y
);

  typedef enum logic [2:0] {
    ST_LOAD,
    ST_START,
    ST_WAIT,
    ST_CAPT,
    ST_UNLOAD
  } state_t;

  state_t         state;
  logic [2:0]     wcnt;
  logic [3:0]     beat;
  logic [238:0]   d_reg;
  logic [238:0]   x_reg;
  logic [238:0]   y_reg;
  logic           done_q;
  logic           done_rise;
  logic           timeout_hit;
  logic           err_q;
  logic [238:0]   coord;
  logic [31:0]    word;

  // Only a fresh rising edge counts; a level left high by a previous run is ignored.
  assign done_rise = core_done & ~done_q;

`ifdef SECT239K1_PT_MUL_IF_TIMEOUT_EN
  logic [31:0] wd_cnt;

  // Counter is 0 in the first WAIT cycle, so the hit lands in WAIT cycle TimeoutCycles.
  assign timeout_hit = (state == ST_WAIT) && !done_rise &&
                       (wd_cnt == 32'(TimeoutCycles - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt <= '0;
    end else if (state == ST_WAIT) begin
      wd_cnt <= wd_cnt + 32'd1;
    end else begin
      wd_cnt <= '0;
    end
  end
`else
  wire unused_timeout_cycles = ^TimeoutCycles;
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_LOAD;
      wcnt   <= '0;
      beat   <= '0;
      d_reg  <= '0;
      x_reg  <= '0;
      y_reg  <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      done_q <= core_done;
      if (clr) begin
        // clr outranks any handshake in the same cycle; the word is dropped.
        state <= ST_LOAD;
        wcnt  <= '0;
        beat  <= '0;
        d_reg <= '0;
        err_q <= 1'b0;
      end else begin
        case (state)
          ST_LOAD: begin
            if (s_valid) begin
              if (wcnt == 3'd7) begin
                // Top word carries only bits 238:224; the rest is discarded.
                d_reg[238:224] <= s_data[14:0];
                state          <= ST_START;
              end else begin
                for (int i = 0; i < 7; i++) begin
                  if (wcnt == i[2:0]) d_reg[32*i +: 32] <= s_data;
                end
              end
              wcnt <= wcnt + 3'd1;
            end
          end
          ST_START: state <= ST_WAIT;
          ST_WAIT: begin
            if (done_rise) begin
              state <= ST_CAPT;
            end else if (timeout_hit) begin
              err_q <= 1'b1;
              d_reg <= '0;
              state <= ST_LOAD;
            end
          end
          ST_CAPT: begin
            x_reg <= core_x;
            y_reg <= core_y;
            state <= ST_UNLOAD;
          end
          ST_UNLOAD: begin
            if (m_ready) begin
              beat <= beat + 4'd1;
              if (beat == 4'd15) begin
                d_reg <= '0;
                state <= ST_LOAD;
              end
            end
          end
          default: state <= ST_LOAD;
        endcase
      end
    end
  end

  // Output word mux; beat only moves on a handshake, so m_data holds under stall.
  always_comb begin
    coord = beat[3] ? y_reg : x_reg;
    word  = 32'd0;
    if (beat[2:0] == 3'd7) begin
      word = {17'd0, coord[238:224]};
    end else begin
      for (int i = 0; i < 7; i++) begin
        if (beat[2:0] == i[2:0]) word = coord[32*i +: 32];
      end
    end
  end

  assign s_ready    = (state == ST_LOAD);
  assign m_valid    = (state == ST_UNLOAD);
  assign m_data     = (state == ST_UNLOAD) ? word : 32'd0;
  assign m_last     = (state == ST_UNLOAD) && (beat == 4'd15);
  assign busy       = (state != ST_LOAD);
  assign err        = err_q;
  assign core_clr   = clr | timeout_hit;
  assign core_start = (state == ST_START);
  assign core_d     = ((state == ST_START) || (state == ST_WAIT) || (state == ST_CAPT))
                      ? d_reg : 239'd0;

endmodule

// File: tb/tb_sect239k1_pt_mul_if.sv
// tb/tb_sect239k1_pt_mul_if.sv - directed self-checking bench for sect239k1_pt_mul_if

module tb_sect239k1_pt_mul_if;

  logic         clk;
  logic         rst_n;
  logic         clr;
  logic         s_valid;
  logic         s_ready;
  logic [31:0]  s_data;
  logic         m_valid;
  logic         m_ready;
  logic [31:0]  m_data;
  logic         m_last;
  logic         busy;
  logic         err;
  logic         core_clr;
  logic         core_start;
  logic [238:0] core_d;
  logic         core_done;
  logic [238:0] core_x;
  logic [238:0] core_y;

  int n_vec;
  int n_err;

  sect239k1_pt_mul_if #(.TimeoutCycles(50)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_last     (m_last),
    .busy       (busy),
    .err        (err),
    .core_clr   (core_clr),
    .core_start (core_start),
    .core_d     (core_d),
    .core_done  (core_done),
    .core_x     (core_x),
    .core_y     (core_y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chkw(input string tag, input logic [238:0] obs, input logic [238:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_word(input logic [238:0] ex, input logic [238:0] ey,
                                           input int j);
    logic [238:0] c;
    c = (j < 8) ? ex : ey;
    if ((j % 8) == 7) return {17'd0, c[238:224]};
    return c[32*(j%8) +: 32];
  endfunction

  task automatic send_word(input logic [31:0] w, input int gap);
    int n;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = w;
    n = 0;
    while (!s_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n == 50) chk1("s_ready_timeout", 1'b0, 1'b1);
    @(posedge clk);
    #1 s_valid = 1'b0;
  endtask

  task automatic send_scalar(input logic [255:0] ws, input int gapmax);
    for (int k = 0; k < 8; k++)
      send_word(ws[32*k +: 32], (gapmax > 0) ? int'($urandom_range(0, gapmax)) : 0);
  endtask

  // Called at #1 after the 8th handshake edge.
  task automatic start_check(input logic [238:0] exp_d);
    chk1("core_start_pulse", core_start, 1'b1);
    chkw("core_d_at_start", core_d, exp_d);
    @(posedge clk);
    #1;
    chk1("core_start_one_cycle", core_start, 1'b0);
  endtask

  task automatic raise_done(input logic [238:0] x, input logic [238:0] y, input int delay);
    repeat (delay) @(negedge clk);
    @(negedge clk);
    core_x    = x;
    core_y    = y;
    core_done = 1'b1;
    @(posedge clk);
    #1;
    chk1("capt_no_valid_yet", m_valid, 1'b0);
    @(posedge clk);
    #1;
    chk1("m_valid_after_capt", m_valid, 1'b1);
  endtask

  task automatic recv(input logic [238:0] ex, input logic [238:0] ey,
                      input bit toggle, input int nbeats);
    int  j;
    int  cyc;
    bit  adv;
    j   = 0;
    cyc = 0;
    while (j < nbeats && cyc < 200) begin
      @(negedge clk);
      m_ready = toggle ? cyc[0] : 1'b1;
      if (m_valid) begin
        chkw("m_data_beat", {207'd0, m_data}, {207'd0, exp_word(ex, ey, j)});
        chk1("m_last_beat", m_last, j == 15);
        if (j == 0) chk1("busy_unload", busy, 1'b1);
      end
      adv = m_valid && m_ready;
      @(posedge clk);
      if (adv) j++;
      cyc++;
    end
    #1 m_ready = 1'b0;
    if (j < nbeats) chk1("recv_timeout", 1'b0, 1'b1);
    if (nbeats == 16) begin
      chk1("s_ready_after_last", s_ready, 1'b1);
      chk1("m_valid_after_last", m_valid, 1'b0);
      chk1("busy_after_last", busy, 1'b0);
    end
  endtask

  logic [255:0] ws;
  logic [238:0] xa;
  logic [238:0] ya;
  int           n;
  int           seen;

  initial begin
    n_vec     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    clr       = 1'b0;
    s_valid   = 1'b0;
    s_data    = 32'd0;
    m_ready   = 1'b0;
    core_done = 1'b0;
    core_x    = '0;
    core_y    = '0;

    repeat (3) @(negedge clk);
    chk1("rst_s_ready", s_ready, 1'b1);
    chk1("rst_m_valid", m_valid, 1'b0);
    chkw("rst_m_data", {207'd0, m_data}, 239'd0);
    chk1("rst_m_last", m_last, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_err", err, 1'b0);
    chk1("rst_core_start", core_start, 1'b0);
    chkw("rst_core_d", core_d, 239'd0);
    chk1("rst_core_clr", core_clr, 1'b0);
    rst_n = 1'b1;

    // Scalar = 1, result x=0x1234 y=0x5678 after 100 cycles.
    ws = {224'd0, 32'h0000_0001};
    send_scalar(ws, 0);
    start_check(239'h1);
    raise_done(239'h1234, 239'h5678, 98);
    recv(239'h1234, 239'h5678, 1'b0, 16);

    // All ones; done is still high from the previous run and must be ignored.
    ws = {8{32'hFFFF_FFFF}};
    send_scalar(ws, 0);
    start_check({239{1'b1}});
    repeat (20) @(negedge clk);
    chk1("stale_done_no_capt", m_valid, 1'b0);
    chk1("stale_done_busy", busy, 1'b1);
    core_done = 1'b0;
    repeat (3) @(negedge clk);
    raise_done({239{1'b1}}, {239{1'b1}}, 0);
    @(negedge clk);
    chkw("word0_ones", {207'd0, m_data}, {207'd0, 32'hFFFF_FFFF});
    recv({239{1'b1}}, {239{1'b1}}, 1'b0, 16);

    // Stalling sink, gappy source.
    ws = {32'h7777_7777, 32'h6666_6666, 32'h5555_5555, 32'h4444_4444,
          32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h0123_4567};
    send_scalar(ws, 3);
    start_check(ws[238:0]);
    xa = {15'h1357, {7{32'h0BAD_F00D}}};
    ya = {15'h2468, {7{32'hFEED_FACE}}};
    core_done = 1'b0;
    raise_done(xa, ya, 5);
    recv(xa, ya, 1'b1, 16);

    // clr after 4 words (coincident word dropped), then during beat 5.
    for (int k = 0; k < 4; k++) send_word(32'hDEAD_0000 + k, 0);
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = 32'hAAAA_AAAA;
    clr     = 1'b1;
    #1 chk1("core_clr_load", core_clr, 1'b1);
    @(posedge clk);
    #1;
    clr     = 1'b0;
    s_valid = 1'b0;
    chk1("clr_load_s_ready", s_ready, 1'b1);
    ws = {32'h0000_4321, 32'h0000_0007, 32'h0000_0006, 32'h0000_0005,
          32'h0000_0004, 32'h0000_0003, 32'h0000_0002, 32'h0000_0001};
    send_scalar(ws, 0);
    start_check({15'h4321, 32'h7, 32'h6, 32'h5, 32'h4, 32'h3, 32'h2, 32'h1});
    core_done = 1'b0;
    raise_done(xa, ya, 2);
    recv(xa, ya, 1'b0, 5);
    @(negedge clk);
    chkw("beat5_data", {207'd0, m_data}, {207'd0, 32'h0BAD_F00D});
    clr = 1'b1;
    #1 chk1("core_clr_unload", core_clr, 1'b1);
    @(posedge clk);
    #1;
    clr = 1'b0;
    chk1("clr_unload_m_valid", m_valid, 1'b0);
    chk1("clr_unload_s_ready", s_ready, 1'b1);
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (m_valid) seen++;
    end
    chk1("no_valid_after_clr", seen == 0, 1'b1);

    // Core never answers.
    core_done = 1'b0;
    send_scalar(256'h1, 0);
`ifdef SECT239K1_PT_MUL_IF_TIMEOUT_EN
    n = 0;
    seen = 0;
    while (n < 200 && seen == 0) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (core_clr) seen = 1;
    end
    chk1("timeout_core_clr_seen", seen == 1, 1'b1);
    chkw("timeout_cycle", 239'(n), 239'd50);
    chk1("err_before_edge", err, 1'b0);
    @(posedge clk);
    #1;
    chk1("timeout_err", err, 1'b1);
    chk1("timeout_s_ready", s_ready, 1'b1);
    chk1("timeout_core_clr_one_cycle", core_clr, 1'b0);
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    chk1("err_cleared", err, 1'b0);
`else
    repeat (200) @(posedge clk);
    @(negedge clk);
    chk1("no_timeout_busy", busy, 1'b1);
    chk1("no_timeout_err", err, 1'b0);
    chk1("no_timeout_s_ready", s_ready, 1'b0);
    chk1("no_timeout_core_clr", core_clr, 1'b0);
    clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
    chk1("clr_from_wait", s_ready, 1'b1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
